// File: rtl/rvfi_sched_pkg.sv
// Shared width helpers and channel-compaction functions for the RVFI channel scheduler.
package rvfi_sched_pkg;

    localparam int unsigned MAX_NRET = 32;
    localparam int unsigned ORDER_W  = 16;

    // $clog2 with a floor of one bit, for pointer, channel-id and skip widths
    function automatic int unsigned width_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned popcount_nret(input logic [MAX_NRET-1:0] v);
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < MAX_NRET; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    // Lowest set index at or above 'from'; MAX_NRET when there is none
    function automatic int unsigned first_set_from(input logic [MAX_NRET-1:0] v,
                                                   input int unsigned from);
        int unsigned r;
        logic        found;
        r     = MAX_NRET;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_NRET; i++) begin
            if (!found && i >= from && v[i]) begin
                r     = i;
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rvfi_sched_fifo.sv
// Multi-push, single-pop FIFO: up to NRET compacted entries written per cycle, all-or-nothing.
module rvfi_sched_fifo
    import rvfi_sched_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned EW    = 257,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NRET-1:0]    push_valid,
    input  logic [NRET*EW-1:0] push_data,
    input  logic               pop,
    output logic               head_valid,
    output logic [EW-1:0]      head_data,
    output logic               space_ok,
    output logic               drop
);

    localparam int unsigned PW = width_min1(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [EW-1:0] slot_data [NRET];
    int unsigned   knum;
    int unsigned   free_n;
    logic          accept;

    always_comb begin
        int unsigned pos;
        int unsigned ch;
        knum   = popcount_nret(MAX_NRET'(push_valid));
        free_n = DEPTH - int'(count);
        accept = (knum != 0) && (knum <= free_n);
        drop   = (knum != 0) && !accept;
        pos    = 0;
        // Slot j receives the j-th valid channel in ascending index order
        for (int unsigned j = 0; j < NRET; j++) begin
            slot_data[j] = '0;
            ch = first_set_from(MAX_NRET'(push_valid), pos);
            if (ch < NRET) begin
                slot_data[j] = push_data[ch*EW +: EW];
                pos = ch + 1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int unsigned j = 0; j < NRET; j++) begin
                if (j < knum) begin
                    mem[wr_ptr + PW'(j)] <= slot_data[j];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(knum);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + (accept ? CW'(knum) : '0) - CW'(pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign space_ok   = (free_n >= NRET);

endmodule

// File: rtl/rvfi_channel_sched.sv
// Serialises NRET RVFI retirement channels onto one checker port, with a retirement skip window.
module rvfi_channel_sched
    import rvfi_sched_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned WIDTH = 256,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SKIP  = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NRET-1:0]             rvfi_valid,
    input  logic [NRET*WIDTH-1:0]       rvfi_data,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [width_min1(NRET)-1:0] out_channel,
    output logic [ORDER_W-1:0]          out_order,
    input  logic                        out_ready,
    output logic                        check,
    output logic                        overflow
);

    localparam int unsigned CHW = width_min1(NRET);
    localparam int unsigned EW  = CHW + WIDTH;
    localparam int unsigned SW  = width_min1(SKIP + 1);

    logic [NRET*EW-1:0] push_data;
    logic [EW-1:0]      head_data;
    logic [SW-1:0]      skipped;
    logic               pop;
    logic               drop;

    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < NRET; i++) begin
            push_data[i*EW +: EW] = {CHW'(i), rvfi_data[i*WIDTH +: WIDTH]};
        end
    end

    rvfi_sched_fifo #(
        .NRET  (NRET),
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (rvfi_valid),
        .push_data  (push_data),
        .pop        (pop),
        .head_valid (out_valid),
        .head_data  (head_data),
        .space_ok   (in_ready),
        .drop       (drop)
    );

    assign out_channel = head_data[EW-1 -: CHW];
    assign out_data    = head_data[WIDTH-1:0];
    assign pop         = out_valid && out_ready;
    assign check       = pop && (skipped == SW'(SKIP)) && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            skipped   <= '0;
            out_order <= '0;
            overflow  <= 1'b0;
        end else begin
            if (pop && skipped != SW'(SKIP)) begin
                skipped <= skipped + SW'(1);
            end
            if (pop && out_order != '1) begin
                out_order <= out_order + ORDER_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_channel_sched.sv
// Scoreboard bench: directed pushes queue expected packets; a monitor thread checks each pop.
module tb_rvfi_channel_sched;

    typedef struct packed {
        logic [31:0] data;
        logic        ch;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [1:0]  rvfi_valid;
    logic [63:0] rvfi_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_channel, a_check, a_overflow;
    logic [31:0] a_out_data;
    logic [15:0] a_out_order;
    logic        b_in_ready, b_out_valid, b_out_channel, b_check, b_overflow;
    logic [31:0] b_out_data;
    logic [15:0] b_out_order;

    int   vectors;
    int   miscompares;
    exp_t q[$];
    int   exp_order;

    rvfi_channel_sched #(.NRET(2), .WIDTH(32), .DEPTH(4), .SKIP(0)) dut_a (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_data(rvfi_data),
        .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data),
        .out_channel(a_out_channel), .out_order(a_out_order), .out_ready(out_ready),
        .check(a_check), .overflow(a_overflow)
    );

    rvfi_channel_sched #(.NRET(2), .WIDTH(32), .DEPTH(4), .SKIP(3)) dut_b (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_data(rvfi_data),
        .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
        .out_channel(b_out_channel), .out_order(b_out_order), .out_ready(out_ready),
        .check(b_check), .overflow(b_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                        input logic rdy, input logic exp_acc);
        rvfi_valid = v;
        rvfi_data  = {d1, d0};
        out_ready  = rdy;
        if (exp_acc) begin
            if (v[0]) q.push_back({d0, 1'b0});
            if (v[1]) q.push_back({d1, 1'b1});
        end
        @(posedge clock);
        #1;
        rvfi_valid = '0;
        rvfi_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        exp_order = 0;
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_check", 64'(a_check), 64'(0));
        chk("rst_overflow", 64'(a_overflow), 64'(0));
        chk("rst_b_overflow", 64'(b_overflow), 64'(0));
        chk("rst_out_order", 64'(a_out_order), 64'(0));
        chk("rst_out_data", 64'(a_out_data), 64'(0));
        chk("rst_out_channel", 64'(a_out_channel), 64'(0));
        chk("rst_in_ready", 64'(a_in_ready), 64'(1));
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_order   = 0;
        reset       = 1'b0;
        rvfi_valid  = '0;
        rvfi_data   = '0;
        out_ready   = 1'b0;
        fork
            // Monitor: every pop seen at the falling edge is matched against the scoreboard
            forever begin
                exp_t e;
                @(negedge clock);
                if (!reset && a_out_valid && out_ready) begin
                    chk("sb_nonempty", 64'(q.size() != 0), 64'(1));
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk("pop_data", 64'(a_out_data), 64'(e.data));
                        chk("pop_channel", 64'(a_out_channel), 64'(e.ch));
                        chk("pop_order", 64'(a_out_order), 64'(exp_order));
                        chk("pop_check", 64'(a_check), 64'(1));
                        chk("skip_data", 64'(b_out_data), 64'(e.data));
                        chk("skip_channel", 64'(b_out_channel), 64'(e.ch));
                        chk("skip_order", 64'(b_out_order), 64'(exp_order));
                        chk("skip_check", 64'(b_check), 64'(exp_order >= 3));
                    end
                    exp_order++;
                end else if (!reset && a_out_valid) begin
                    chk("hold_check", 64'(a_check), 64'(0));
                    chk("hold_b_valid", 64'(b_out_valid), 64'(1));
                end
            end
            begin
                #2;
                do_reset();
                // Single retirement, then a pair delivered in channel order
                step(2'b01, 32'hA000_0001, 32'h0, 1'b1, 1'b1);
                step(2'b11, 32'hB000_0000, 32'hB000_0001, 1'b1, 1'b1);
                step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                chk("pair_drained", 64'(a_out_valid), 64'(0));
                chk("no_overflow", 64'(a_overflow), 64'(0));
                // Fill to DEPTH with out_ready low, then one more push is dropped
                step(2'b11, 32'hC000_0000, 32'hC000_0001, 1'b0, 1'b1);
                step(2'b11, 32'hC000_0002, 32'hC000_0003, 1'b0, 1'b1);
                chk("full_in_ready", 64'(a_in_ready), 64'(0));
                chk("full_b_in_ready", 64'(b_in_ready), 64'(0));
                step(2'b01, 32'hD000_0000, 32'h0, 1'b0, 1'b0);
                chk("full_overflow", 64'(a_overflow), 64'(1));
                for (int i = 0; i < 4; i++) step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                chk("sticky_overflow", 64'(a_overflow), 64'(1));
                chk("full_drained", 64'(a_out_valid), 64'(0));
                // Count 3, pair arrives during a pop: whole pair dropped
                do_reset();
                step(2'b11, 32'hE000_0000, 32'hE000_0001, 1'b0, 1'b1);
                chk("cnt2_in_ready", 64'(a_in_ready), 64'(1));
                step(2'b01, 32'hE000_0002, 32'h0, 1'b0, 1'b1);
                chk("cnt3_in_ready", 64'(a_in_ready), 64'(0));
                step(2'b11, 32'hF000_0000, 32'hF000_0001, 1'b1, 1'b0);
                chk("pair_drop_overflow", 64'(a_overflow), 64'(1));
                chk("pair_drop_b_overflow", 64'(b_overflow), 64'(1));
                chk("cnt2_after_drop", 64'(a_in_ready), 64'(1));
                step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                chk("drop_drained", 64'(a_out_valid), 64'(0));
                // Alternating single pushes and pops wrap both pointers
                for (int i = 0; i < 10; i++) begin
                    step((i % 2 == 1) ? 2'b10 : 2'b01, 32'h5700_0000 + 32'(i),
                         32'h5710_0000 + 32'(i), 1'b1, 1'b1);
                end
                step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                step(2'b11, 32'h6000_0000, 32'h6000_0001, 1'b0, 1'b1);
                chk("cnt2_valid", 64'(a_out_valid), 64'(1));
                chk("pre_reset_overflow", 64'(a_overflow), 64'(1));
                // Asynchronous reset with two entries held
                do_reset();
                step(2'b10, 32'h0, 32'h7000_0001, 1'b1, 1'b1);
                step(2'b00, 32'h0, 32'h0, 1'b1, 1'b0);
                chk("end_empty", 64'(a_out_valid), 64'(0));
                chk("sb_empty", 64'(q.size()), 64'(0));
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
        join_any
    end

endmodule

// File: doc/rvfi_channel_sched.md
# rvfi_channel_sched

Scheduler between a multi-retirement core's RVFI bus (NRET channels per cycle) and one single-channel instruction checker. Each cycle it captures all valid channel packets in program order (lowest channel index first) into a small multi-push FIFO. It replays them one per cycle with a `check` strobe, so a single checker instance covers every channel. A programmable retirement skip lets the check window open only after a chosen number of instructions have retired.

## Interface
Parameters:
- `NRET`, 2: RVFI channels per cycle.
- `WIDTH`, 256: bits per channel packet (packed per-channel RVFI fields, opaque to this block).
- `DEPTH`, 4: FIFO entries. Power of two, ≥ NRET.
- `SKIP`, 0: retirements popped without `check` before checking starts.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `rvfi_valid`  in  NRET: per-channel retirement valid.
- `rvfi_data`  in  NRET*WIDTH: channel i at `[i*WIDTH +: WIDTH]`.
- `in_ready`  out  1: free entries ≥ NRET (from registered count only).
- `out_valid`  out  1: head entry present.
- `out_data`  out  WIDTH: head packet.
- `out_channel`  out  $clog2(NRET) (min 1): source channel of head.
- `out_order`  out  16: pop index of head, saturating at 16'hFFFF.
- `out_ready`  in  1: checker consumes head this cycle.
- `check`  out  1: `out_valid && out_ready && skipped == SKIP`.
- `overflow`  out  1: sticky; a push cycle was dropped.

## Operation
- Push: in a cycle where popcount(`rvfi_valid`) = k > 0 and free = DEPTH − count ≥ k, write the valid channels in ascending index order to `wr_ptr`, `wr_ptr+1`, … `wr_ptr += k`.
- Insufficient space (free < k): drop all k packets of that cycle, never a partial set. Set `overflow` = 1 until reset.
- Free space uses the registered count only. A same-cycle pop does not create push space.
- Pop: when `out_valid && out_ready`, `rd_ptr += 1`, `out_order` += 1 (saturating).
- Skip counter `skipped` (width $clog2(SKIP+1), min 1) increments on each pop while < SKIP, then holds.
- Count update: count_next = count + k_accepted − pop. Simultaneous push and pop are legal, including at full and at empty. A pop at empty is impossible because `out_valid` = 0.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided by count (width $clog2(DEPTH+1)), not by pointer compare.
- `out_valid` = (count != 0). `out_data` and `out_channel` are read combinationally from the storage at `rd_ptr`.
- `out_ready` low with `out_valid` high: head, `out_order` and `check` hold; `check` = 0.

## Timing
- Reset values: count 0, `wr_ptr` 0, `rd_ptr` 0, `out_valid` 0, `check` 0, `overflow` 0, `out_order` 0, `skipped` 0.
- `out_data` and `out_channel` reset to 0; storage contents after reset are don't-care.
- Latency: a packet pushed in cycle N appears at the head in cycle N+1 at the earliest (FIFO empty at N).
- Throughput: 1 pop per cycle. Sustained input above 1 retirement per cycle eventually overflows.
- `in_ready` is informational; the core is not back-pressured. Formal benches may assume it.
- Reset asserted mid-operation: all entries discarded immediately (asynchronous). No `check` in any cycle with `reset` high.
- `check` is combinational from `out_ready` and registered state, with no extra delay.

## Structure
- Shared package `rvfi_sched_pkg`:
  - `localparam` helpers for pointer and count widths.
  - Function `popcount_nret`.
  - Function `first_set_from`, used for the ascending channel compaction.
- Sub-module `rvfi_sched_fifo`: multi-push (up to NRET per cycle, compacted) single-pop storage with count, parameterised by WIDTH+channel-id width and DEPTH.
- The top level holds the skip counter, order counter, overflow flag and `check` logic.

## Test plan
- Reset, then `rvfi_valid`=2'b01 with data A at cycle 1 → `out_valid`=1, `out_data`=A, `out_channel`=0 at cycle 2. With `out_ready`=1: `check`=1, `out_order`=0.
- `rvfi_valid`=2'b11 (A ch0, B ch1) in one cycle, `out_ready`=1 → A then B on consecutive cycles, `out_order` 0 then 1, count returns to 0.
- SKIP=3, five single retirements with `out_ready`=1 → `check` = 0,0,0,1,1.
- DEPTH=4, `out_ready`=0: pushes of 2'b11, 2'b11 → count 4, `in_ready`=0. Next push 2'b01 → dropped, `overflow`=1 and sticky, count stays 4.
- Count 3, push 2'b11 while popping → free=1 < 2, whole pair dropped, `overflow`=1, count 2.
- Wrap and reset: 10 alternating pushes/pops → `rd_ptr`/`wr_ptr` wrap, data order preserved. Assert `reset` with count 2 → `out_valid`=0, count 0 and `overflow`=0 in the same cycle.
